adder_seq_ctrl: RTL
===================

Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that performs wide add/subtract by time-sharing one 8-bit ripple-carry byte adder, one byte per clock, LSB first.
- Inter-byte carry is held in a flip-flop between cycles.
- Sits between a requesting controller (start/ready handshake) and the byte adder; returns a wide result, carry-out and a done pulse.
- Trades latency (NBYTES cycles) for area versus a full-width adder.

Parameters:
NBYTES, 4, operand width in bytes; legal range 1..16; derived localparam W = 8*NBYTES.

Ports:
iClk  input  1  clock; all state updates on the rising edge.
iRst  input  1  reset; synchronous, active-high.
iStart  input  1  request; accepted on an edge where iStart=1 and oReady=1.
oReady  output  1  1 only in IDLE.
iSub  input  1  0 = A+B+iC; 1 = A-B (A + ~B + 1, iC ignored). Sampled at accept.
iData_a  input  W  operand A, sampled at accept.
iData_b  input  W  operand B, sampled at accept.
iC  input  1  carry-in for add, sampled at accept.
oData  output  W  result; held stable between DONE entries.
oData_C  output  1  final carry-out (for subtract, 1 = no borrow); held with oData.
oBusy  output  1  1 in RUN and DONE.
oDone  output  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset (iRst=1 at an edge, any state):
  - state=IDLE; oData=0, oData_C=0, oDone=0, oBusy=0, oReady=1.
  - Internal operand regs, carry reg and byte counter all cleared.
  - An operation in flight is abandoned; no oDone is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - On iStart=1: load a_q=iData_a and b_q = iSub ? ~iData_b : iData_b.
  - Load carry_q = iSub ? 1 : iC; cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Byte adder inputs: a_q[7:0], b_q[7:0], carry_q.
  - Sum byte is shifted into res_q from the top (res_q <= {sum, res_q[W-1:8]}).
  - a_q and b_q shift right by 8; carry_q <= byte carry-out; cnt++.
  - When cnt = NBYTES-1: commit oData <= {sum, res_q[W-1:8]} and oData_C <= carry-out, then go to DONE.
- DONE: oDone=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency:
  - Accept on edge k; last byte processed on edge k+NBYTES.
  - oDone is high in the cycle following edge k+NBYTES.
  - Next accept is possible no earlier than edge k+NBYTES+2.
- iStart while not in IDLE: ignored (no queuing). Operand/iSub/iC changes after accept have no effect.
- NBYTES=1: RUN lasts one cycle; res_q shift degenerates to a direct load.
- Arithmetic is modulo 2^W. Carry wraps naturally; nothing saturates.
- Simultaneous iRst and iStart: reset wins.

Optional Feature:
ADDSEQ_OVF_EN
- Defined:
  - Adds output port oOvf (1 bit) giving two's-complement signed overflow.
  - oOvf = (a_msb == beff_msb) && (res_msb != a_msb), where beff is B after inversion for subtract.
  - Computed from the last byte in RUN and registered alongside oData.
  - Reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package/header:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - BYTE_W=8.
  - default NBYTES.
- Sub-module: the team's existing 8-bit ripple-carry byte adder, instantiated once as the datapath.
- No new sub-module; the controller is a single module.

Test Plan:
All cases use NBYTES=4.
1. Add 0x000000FF + 0x00000001, iC=0 -> oData=0x00000100, oData_C=0; oDone exactly 4 cycles after the accept edge; oBusy high throughout.
2. Add 0xFFFFFFFF + 0x00000000, iC=1 -> oData=0x00000000, oData_C=1 (carry propagates through all 4 byte slots).
3. Sub 0x00000005 - 0x00000007 -> oData=0xFFFFFFFE, oData_C=0; sub 0x00000007 - 0x00000005 -> oData=0x00000002, oData_C=1.
4. Hold iStart=1 and change operands during RUN/DONE -> oReady=0, result unaffected, exactly one oDone. A second op is accepted only in IDLE and gives the correct independent result.
5. Assert iRst in the 2nd RUN cycle -> the next cycle shows IDLE, oReady=1, oData=0, oData_C=0, and oDone never pulses; a subsequent 0x12345678+0x11111111 gives 0x23456789.
6. With ADDSEQ_OVF_EN:
   - 0x7FFFFFFF + 1 -> oOvf=1
   - sub 0x80000000 - 1 -> oOvf=1
   - 1 + 1 -> oOvf=0
   - Without the macro, the build elaborates without oOvf.

Source files
------------

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer:
// state encoding, byte width and the default operand size.
package adder_seq_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_seq_ctrl_byte_add.sv
// 8-bit ripple-carry byte adder; the sequencer time-shares one instance across all operand bytes.
module adder_seq_ctrl_byte_add
  import adder_seq_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              c_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              c_o
);

  logic [BYTE_W:0] carry;

  always_comb begin
    carry[0] = c_i;
    sum_o    = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[BYTE_W];
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract sequencer: one byte per clock, LSB first, through a shared byte adder.
// Define ADDSEQ_OVF_EN to add the oOvf signed-overflow output.
//
// state   | meaning
// IDLE    | waiting for iStart; oReady=1
// RUN     | one operand byte per cycle through the byte adder
// DONE    | one-cycle oDone pulse, result registers stable
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter  int NBYTES = NBYTES_DEF,
  localparam int W      = BYTE_W * NBYTES
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  output logic         oReady,
  input  logic         iSub,
  input  logic [W-1:0] iData_a,
  input  logic [W-1:0] iData_b,
  input  logic         iC,
  output logic [W-1:0] oData,
  output logic         oData_C,
  output logic         oBusy,
  output logic         oDone
`ifdef ADDSEQ_OVF_EN
  ,
  output logic         oOvf
`endif
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    data_q, data_d;
  logic            carry_q, carry_d;
  logic            data_c_q, data_c_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [BYTE_W-1:0] sum;
  logic              byte_co;
  logic [W-1:0]      res_shift;

  adder_seq_ctrl_byte_add u_byte_add (
    .a_i   (a_q[BYTE_W-1:0]),
    .b_i   (b_q[BYTE_W-1:0]),
    .c_i   (carry_q),
    .sum_o (sum),
    .c_o   (byte_co)
  );

  // Result fills from the top so the first (LSB) byte lands at the bottom after NBYTES shifts.
  generate
    if (NBYTES == 1) begin : g_one
      assign res_shift = sum;
    end else begin : g_multi
      assign res_shift = {sum, res_q[W-1:BYTE_W]};
    end
  endgenerate

`ifdef ADDSEQ_OVF_EN
  logic ovf_q, ovf_d;
  // On the last byte a_q/b_q hold the operand MSB bytes; b_q is already inverted for subtract.
  wire  ovf_last = (a_q[BYTE_W-1] == b_q[BYTE_W-1]) && (sum[BYTE_W-1] != a_q[BYTE_W-1]);
  assign oOvf = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    data_d   = data_q;
    carry_d  = carry_q;
    data_c_d = data_c_q;
    cnt_d    = cnt_q;
`ifdef ADDSEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = iData_a;
          b_d     = iSub ? ~iData_b : iData_b;
          carry_d = iSub ? 1'b1 : iC;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d   = res_shift;
        a_d     = a_q >> BYTE_W;
        b_d     = b_q >> BYTE_W;
        carry_d = byte_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          data_d   = res_shift;
          data_c_d = byte_co;
`ifdef ADDSEQ_OVF_EN
          ovf_d    = ovf_last;
`endif
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      data_c_q <= 1'b0;
      cnt_q    <= '0;
`ifdef ADDSEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      data_c_q <= data_c_d;
      cnt_q    <= cnt_d;
`ifdef ADDSEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign oReady  = (state_q == ST_IDLE);
  assign oBusy   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign oDone   = (state_q == ST_DONE);
  assign oData   = data_q;
  assign oData_C = data_c_q;

endmodule
